servo_pulse_decoder: RTL and testbench

Receive-side counterpart to the servo controller's PWM output. The block samples a servo-style PWM line (700–2300 µs pulse, ~20 ms frame), measures the high time in 10 µs ticks, and converts it back to an angle of 0–180. It sits between an external PWM input pin and downstream logic that needs a commanded servo angle, such as loopback checking or RC-receiver capture.

---
 rtl/servo_pulse_decoder.sv | 169 ++++++++++++++++
 tb/tb_servo_pulse_decoder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/servo_pulse_decoder.sv
// Servo PWM receiver: measures the high time of a servo-style pulse in ticks
// and converts it back to a 0-180 angle, with range and loss-of-signal flags.
module servo_pulse_decoder #(
  parameter int unsigned TICK_DIV      = 1000,
  parameter int unsigned MIN_PW        = 70,
  parameter int unsigned MAX_PW        = 230,
  parameter int unsigned TIMEOUT_TICKS = 2500
) (
  input  logic        clk_100M,
  input  logic        rst_n,
  input  logic        en,
  input  logic        pwm_in,
  output logic [7:0]  angle,
  output logic [11:0] pulsewidth,
  output logic        valid,
  output logic        new_sample,
  output logic        err_range,
  output logic        timeout
);

  localparam logic [1:0] WAIT_LOW  = 2'd0;
  localparam logic [1:0] WAIT_RISE = 2'd1;
  localparam logic [1:0] HIGH      = 2'd2;
  localparam logic [1:0] LOW       = 2'd3;

  localparam logic [9:0]  DIV_LAST  = 10'(TICK_DIV - 1);
  localparam logic [11:0] TO_LIMIT  = 12'(TIMEOUT_TICKS);
  localparam logic [11:0] HI_SAT    = 12'hFFF;
  localparam logic [15:0] MIN16     = 16'(MIN_PW);
  localparam logic [15:0] MAX16     = 16'(MAX_PW);
  localparam logic [7:0]  ANGLE_MAX = 8'd180;

  logic        sync1, sync2, sync_d;
  logic [1:0]  fill;
  logic        primed;
  logic        rise, fall;

  logic [1:0]  state;
  logic [9:0]  div;
  logic        tick;
  logic [11:0] hi_cnt, hi_next;
  logic [11:0] period, period_next;
  logic        accept_rise, publish, to_fire;

  logic [15:0] pw16, scaled;
  logic [7:0]  conv_angle;
  logic        conv_err;

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync_d <= 1'b0;
      fill   <= '0;
    end else begin
      sync1  <= pwm_in;
      sync2  <= sync1;
      sync_d <= sync2;
      fill   <= {fill[0], 1'b1};
    end
  end

  // The synchronizer resets to 0, so a line already high at reset release
  // would look low for two cycles; WAIT_LOW ignores it until the flops refill.
  assign primed = fill[1];
  assign rise   = sync2 & ~sync_d;
  assign fall   = ~sync2 & sync_d;
  assign tick   = (div == DIV_LAST);

  assign accept_rise = rise && ((state == WAIT_RISE) || (state == LOW));
  assign publish     = fall && (state == HIGH);

  always_comb begin
    hi_next = hi_cnt;
    if (tick && (hi_cnt != HI_SAT))
      hi_next = hi_cnt + 12'd1;
  end

  always_comb begin
    period_next = period;
    if (tick && (period != TO_LIMIT))
      period_next = period + 12'd1;
  end

  // Edge events outrank timeout; an already-raised timeout is not re-fired.
  assign to_fire = (period_next == TO_LIMIT) && !timeout && !accept_rise && !publish;

  always_comb begin
    pw16       = {4'b0000, hi_next};
    scaled     = '0;
    conv_angle = '0;
    conv_err   = 1'b0;
    if (pw16 < MIN16) begin
      conv_err = 1'b1;
    end else if (pw16 > MAX16) begin
      conv_angle = ANGLE_MAX;
      conv_err   = 1'b1;
    end else begin
      scaled     = ((pw16 - MIN16) * 16'd9) >> 3;
      conv_angle = scaled[7:0];
    end
  end

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_LOW;
      div        <= '0;
      hi_cnt     <= '0;
      period     <= '0;
      angle      <= '0;
      pulsewidth <= '0;
      valid      <= 1'b0;
      new_sample <= 1'b0;
      err_range  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      new_sample <= 1'b0;
      if (!en) begin
        state  <= WAIT_LOW;
        div    <= '0;
        hi_cnt <= '0;
        period <= '0;
        valid  <= 1'b0;
      end else begin
        if (accept_rise || tick)
          div <= '0;
        else
          div <= div + 10'd1;

        period <= accept_rise ? '0 : period_next;

        case (state)
          WAIT_LOW: begin
            if (primed && !sync2)
              state <= WAIT_RISE;
          end
          WAIT_RISE, LOW: begin
            if (rise) begin
              state  <= HIGH;
              hi_cnt <= '0;
            end
          end
          HIGH: begin
            hi_cnt <= hi_next;
            if (fall)
              state <= LOW;
          end
          default: state <= WAIT_LOW;
        endcase

        if (publish) begin
          pulsewidth <= hi_next;
          angle      <= conv_angle;
          err_range  <= conv_err;
          valid      <= 1'b1;
          timeout    <= 1'b0;
          new_sample <= 1'b1;
        end

        if (to_fire) begin
          timeout <= 1'b1;
          valid   <= 1'b0;
          state   <= WAIT_LOW;
        end
      end
    end
  end

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Scoreboard bench for servo_pulse_decoder with a 10-cycle tick so that
// full frames and the loss-of-signal window fit in a short run.
module tb_servo_pulse_decoder;

  localparam int unsigned TICK_DIV      = 10;
  localparam int unsigned TIMEOUT_TICKS = 1000;

  logic        clk_100M = 1'b0;
  logic        rst_n;
  logic        en;
  logic        pwm_in;
  logic [7:0]  angle;
  logic [11:0] pulsewidth;
  logic        valid;
  logic        new_sample;
  logic        err_range;
  logic        timeout;

  servo_pulse_decoder #(
    .TICK_DIV      (TICK_DIV),
    .MIN_PW        (70),
    .MAX_PW        (230),
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) dut (
    .clk_100M   (clk_100M),
    .rst_n      (rst_n),
    .en         (en),
    .pwm_in     (pwm_in),
    .angle      (angle),
    .pulsewidth (pulsewidth),
    .valid      (valid),
    .new_sample (new_sample),
    .err_range  (err_range),
    .timeout    (timeout)
  );

  always #5 clk_100M = ~clk_100M;

  typedef struct {
    int pw;
    int ang;
    int err;
    int at;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   last_rise = 0;
  logic ns_prev = 1'b0;

  always @(posedge clk_100M) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every published sample must match the head of the queue.
  always @(negedge clk_100M) begin
    if (new_sample) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_sample: got pulsewidth=%0d angle=%0d expected no sample (cycle %0d)",
                 pulsewidth, angle, cyc);
      end else begin
        mon_e = q.pop_front();
        check("pulsewidth", int'(pulsewidth), mon_e.pw);
        check("angle", int'(angle), mon_e.ang);
        check("err_range", int'(err_range), mon_e.err);
        check("valid_at_publish", int'(valid), 1);
        check("timeout_at_publish", int'(timeout), 0);
        check("publish_latency", cyc, mon_e.at);
        check("strobe_one_cycle", int'(ns_prev), 0);
      end
    end
    ns_prev <= new_sample;
  end

  task automatic pulse(input int high, input int low, input bit expect_s,
                       input int pw, input int ang, input int err);
    exp_t e;
    @(posedge clk_100M); #1;
    pwm_in    = 1'b1;
    last_rise = cyc;
    repeat (high) @(posedge clk_100M);
    #1;
    pwm_in = 1'b0;
    if (expect_s) begin
      e.pw  = pw;
      e.ang = ang;
      e.err = err;
      e.at  = cyc + 3;
      q.push_back(e);
    end
    repeat (low) @(posedge clk_100M);
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = 1'b1;
    pwm_in = 1'b1;
    repeat (5) @(posedge clk_100M);
    #1;
    check("rst_angle", int'(angle), 0);
    check("rst_pulsewidth", int'(pulsewidth), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_new_sample", int'(new_sample), 0);
    check("rst_err_range", int'(err_range), 0);
    check("rst_timeout", int'(timeout), 0);

    // Line already high at reset release: this pulse must be discarded.
    rst_n = 1'b1;
    repeat (800) @(posedge clk_100M);
    #1 pwm_in = 1'b0;
    repeat (200) @(posedge clk_100M);

    pulse(1500, 200, 1, 150, 90, 0);
    pulse(700,  200, 1, 70,  0,  0);
    pulse(2300, 200, 1, 230, 180, 0);
    pulse(1000, 200, 1, 100, 33, 0);
    pulse(500,  200, 1, 50,  0,  1);
    pulse(2500, 200, 1, 250, 180, 1);
    pulse(1500, 200, 1, 150, 90, 0);
    pulse(1234, 200, 1, 123, 59, 0);
    pulse(1509, 200, 1, 150, 90, 0);

    // Loss of signal after one more pulse.
    pulse(1500, 0, 1, 150, 90, 0);
    while (cyc < last_rise + TIMEOUT_TICKS * TICK_DIV - 1) @(negedge clk_100M);
    check("timeout_early", int'(timeout), 0);
    check("valid_before_timeout", int'(valid), 1);
    while (cyc < last_rise + TIMEOUT_TICKS * TICK_DIV + 3) @(negedge clk_100M);
    check("timeout_set", int'(timeout), 1);
    check("valid_lost", int'(valid), 0);
    check("angle_hold", int'(angle), 90);
    check("pulsewidth_hold", int'(pulsewidth), 150);

    pulse(1500, 200, 1, 150, 90, 0);
    check("timeout_cleared", int'(timeout), 0);
    check("valid_restored", int'(valid), 1);

    // Enable dropped mid-pulse.
    @(posedge clk_100M); #1;
    pwm_in = 1'b1;
    repeat (500) @(posedge clk_100M);
    #1 en = 1'b0;
    repeat (2) @(posedge clk_100M);
    #1;
    check("en_low_valid", int'(valid), 0);
    check("en_low_angle_hold", int'(angle), 90);
    repeat (1000) @(posedge clk_100M);
    #1 pwm_in = 1'b0;
    repeat (50) @(posedge clk_100M);
    #1 en = 1'b1;
    repeat (50) @(posedge clk_100M);
    pulse(1000, 200, 1, 100, 33, 0);

    // Reset asserted mid-pulse clears outputs at once.
    @(posedge clk_100M); #1;
    pwm_in = 1'b1;
    repeat (600) @(posedge clk_100M);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_angle", int'(angle), 0);
    check("midrst_pulsewidth", int'(pulsewidth), 0);
    check("midrst_valid", int'(valid), 0);
    repeat (10) @(posedge clk_100M);
    #1 pwm_in = 1'b0;
    repeat (5) @(posedge clk_100M);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk_100M);
    pulse(700, 200, 1, 70, 0, 0);

    repeat (20) @(posedge clk_100M);
    check("samples_outstanding", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
